// File: rtl/rr_mux_4to1_pkg.sv
// rtl/rr_mux_4to1_pkg.sv - shared constants and lane helper for the 4-to-1 round-robin merger
//
// Purpose: lane count, select width, output-stage state codes and the
//          helper that pulls one lane out of the packed lane bus.
// Ports:   none (package).

package rr_mux_4to1_pkg;

  localparam int N_LANES    = 4;
  localparam int SEL_W      = 2;

  // Widest lane the slice helper can return; callers narrow the result.
  localparam int MAX_LANE_W = 32;

  // Output stage: one register that is either empty or holds a beat.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Extract lane k (lane_w bits wide) from a packed bus; the caller
  // zero-extends its bus to the fixed width and truncates the result.
  function automatic logic [MAX_LANE_W-1:0] lane_slice(
    input logic [N_LANES*MAX_LANE_W-1:0] bus,
    input logic [SEL_W-1:0]              k,
    input int                            lane_w
  );
    return MAX_LANE_W'(bus >> (int'(k) * lane_w));
  endfunction

endpackage

// File: rtl/rr_mux_4to1_arbiter.sv
// rtl/rr_mux_4to1_arbiter.sv - combinational 4-way round-robin arbiter
//
// Purpose: grant the first requester found searching ptr, ptr+1, ptr+2,
//          ptr+3 (mod 4). No request means no grant.
// Ports:   req          - per-lane request
//          ptr          - lane at which the search starts
//          grant_valid  - some lane is granted
//          grant_idx    - index of the granted lane (0 when none)
//          grant_onehot - one-hot form of the grant (0 when none)

module rr_arbiter4
  import rr_mux_4to1_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               grant_valid,
  output logic [SEL_W-1:0]   grant_idx,
  output logic [N_LANES-1:0] grant_onehot
);

  always_comb begin
    grant_valid  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    // Walk from the farthest offset back to ptr so the nearest requester
    // is the last one written and therefore wins. The 2-bit add wraps.
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) begin
        grant_valid = 1'b1;
        grant_idx   = ptr + SEL_W'(i);
      end
    end
    if (grant_valid) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux_4to1.sv
// rtl/rr_mux_4to1.sv - round-robin 4-to-1 stream merger with registered output
//
// Purpose: merge four valid/ready lanes into one registered stream,
//          tagging each beat with the lane it came from.
// Ports:   piClk    - clock
//          piRst_n  - asynchronous active-low reset
//          piE      - packed lane data, lane k at [k*DATA_W +: DATA_W]
//          piValid  - per-lane valid
//          poReady  - per-lane ready (combinational)
//          poData   - registered output data
//          poSel    - lane index that supplied poData
//          poValid  - output beat present
//          piReady  - consumer ready

module rr_mux_4to1
  import rr_mux_4to1_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                  piClk,
  input  logic                  piRst_n,
  input  logic [4*DATA_W-1:0]   piE,
  input  logic [N_LANES-1:0]    piValid,
  output logic [N_LANES-1:0]    poReady,
  output logic [DATA_W-1:0]     poData,
  output logic [SEL_W-1:0]      poSel,
  output logic                  poValid,
  input  logic                  piReady
);

  logic [0:0]         state;
  logic [SEL_W-1:0]   ptr;
  logic               grant_valid;
  logic [SEL_W-1:0]   grant_idx;
  logic [N_LANES-1:0] grant_onehot;
  logic               load_ok;
  logic               take;

  rr_arbiter4 u_arb (
    .req          (piValid),
    .ptr          (ptr),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot)
  );

  assign poValid = (state == ST_FULL);

  // The stage can accept when empty or when its beat leaves this cycle.
  assign load_ok = !poValid || piReady;

  // Gating with piRst_n keeps every ready low while reset is held, even
  // though the stage looks empty then.
  assign take    = piRst_n && load_ok && grant_valid;
  assign poReady = take ? grant_onehot : '0;

  always_ff @(posedge piClk or negedge piRst_n) begin
    if (!piRst_n) begin
      state  <= ST_EMPTY;
      poData <= '0;
      poSel  <= '0;
      ptr    <= '0;
    end else if (take) begin
      // A new beat overwrites any beat drained this same cycle.
      state  <= ST_FULL;
      poData <= DATA_W'(lane_slice((N_LANES*MAX_LANE_W)'(piE), grant_idx, DATA_W));
      poSel  <= grant_idx;
      ptr    <= grant_idx + SEL_W'(1);
    end else if (piReady) begin
      // Drained with nothing to replace it; data and tag stay stale.
      state  <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_rr_mux_4to1.sv
// tb/tb_rr_mux_4to1.sv - self-checking bench for rr_mux_4to1

module tb_rr_mux_4to1;

  localparam int DATA_W = 4;

  typedef struct {
    int         lane;
    logic [3:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        valid = 4'b0000;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] lane_data [4];
  logic [4*DATA_W-1:0] e;
  logic [3:0]        po_ready;
  logic [DATA_W-1:0] po_data;
  logic [1:0]        po_sel;
  logic              po_valid;

  int vectors = 0;
  int miscompares = 0;

  logic       m_valid;
  logic [3:0] m_data;
  int         m_sel;
  int         m_ptr;
  beat_t      sb [$];

  always #5 clk = ~clk;

  always_comb e = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};

  rr_mux_4to1 #(.DATA_W(DATA_W)) dut (
    .piClk   (clk),
    .piRst_n (rst_n),
    .piE     (e),
    .piValid (valid),
    .poReady (po_ready),
    .poData  (po_data),
    .poSel   (po_sel),
    .poValid (po_valid),
    .piReady (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = 4'h0;
    m_sel   = 0;
    m_ptr   = 0;
    sb.delete();
  endfunction

  // Called at a falling edge with inputs already applied; returns the lane
  // that transferred at the next rising edge, or -1.
  task automatic tick(output int xfer);
    logic       lok;
    logic [3:0] er;
    int         g;
    beat_t      b;
    #1;
    lok  = !m_valid || ready;
    g    = model_grant(valid, m_ptr);
    xfer = (lok && g >= 0) ? g : -1;
    er   = (xfer >= 0) ? 4'(1 << xfer) : 4'b0000;
    chk("poReady", po_ready, er);
    if (po_valid && ready) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        b = sb.pop_front();
        chk("sb_data", po_data, b.data);
        chk("sb_lane", po_sel, b.lane);
      end
    end
    @(posedge clk);
    if (xfer >= 0) begin
      sb.push_back(beat_t'{xfer, lane_data[xfer]});
      m_valid = 1'b1;
      m_data  = lane_data[xfer];
      m_sel   = xfer;
      m_ptr   = (xfer + 1) % 4;
    end else if (ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("poValid", po_valid, m_valid);
    chk("poData", po_data, m_data);
    chk("poSel", po_sel, m_sel);
    chk("ptr", dut.ptr, m_ptr);
    @(negedge clk);
  endtask

  // Asserts reset in the low phase, checks the immediate effect, then
  // releases it on the next falling edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", po_valid, 0);
    chk("rst_data", po_data, 0);
    chk("rst_sel", po_sel, 0);
    chk("rst_ready", po_ready, 0);
    chk("rst_ptr", dut.ptr, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    for (int k = 0; k < 4; k++) lane_data[k] = 4'(k);
    model_reset();

    // Held in reset with every lane requesting: nothing may be granted.
    valid = 4'b1111;
    ready = 1'b1;
    @(negedge clk);
    #1;
    chk("init_valid", po_valid, 0);
    chk("init_data", po_data, 0);
    chk("init_sel", po_sel, 0);
    chk("init_ready", po_ready, 0);
    @(negedge clk);
    valid = 4'b0000;
    rst_n = 1'b1;

    // Single lane 1.
    lane_data[1] = 4'h5;
    valid = 4'b0010;
    tick(g);
    chk("single_data", po_data, 4'h5);
    chk("single_sel", po_sel, 1);
    chk("single_ptr", dut.ptr, 2);
    valid = 4'b0000;
    tick(g);

    // Round-robin from ptr=0 with all lanes valid.
    async_reset();
    for (int k = 0; k < 4; k++) lane_data[k] = 4'(k);
    valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick(g);
      chk("rr_sel", po_sel, i % 4);
      chk("rr_data", po_data, i % 4);
    end
    valid = 4'b0000;

    // Back-pressure with lane 3's beat held, then ptr wraps to lane 0.
    lane_data[3] = 4'hC;
    valid = 4'b1000;
    tick(g);
    ready = 1'b0;
    lane_data[0] = 4'h6;
    lane_data[1] = 4'h2;
    valid = 4'b0011;
    tick(g);
    tick(g);
    chk("bp_data", po_data, 4'hC);
    chk("bp_sel", po_sel, 3);
    ready = 1'b1;
    tick(g);
    chk("bp_next_sel", po_sel, 0);
    valid = 4'b0010;
    tick(g);
    chk("bp_then_sel", po_sel, 1);
    valid = 4'b0000;

    // Bring ptr to 1, then lanes 0 and 3 only.
    lane_data[0] = 4'h4;
    valid = 4'b0001;
    tick(g);
    valid = 4'b0000;
    tick(g);
    lane_data[3] = 4'hE;
    lane_data[0] = 4'hB;
    valid = 4'b1001;
    tick(g);
    chk("skip_first", po_sel, 3);
    valid = 4'b0001;
    tick(g);
    chk("skip_second", po_sel, 0);
    chk("skip_ptr", dut.ptr, 1);
    valid = 4'b0000;

    // Drain and load in the same cycle.
    lane_data[0] = 4'h7;
    valid = 4'b0001;
    tick(g);
    lane_data[2] = 4'h9;
    valid = 4'b0100;
    tick(g);
    chk("dl_valid", po_valid, 1);
    chk("dl_data", po_data, 4'h9);
    chk("dl_sel", po_sel, 2);
    valid = 4'b0000;

    // Reset while lane 2's beat is buffered; first grant then from lane 0.
    lane_data[2] = 4'hA;
    valid = 4'b0100;
    tick(g);
    async_reset();
    lane_data[0] = 4'h3;
    lane_data[2] = 4'h8;
    lane_data[3] = 4'hD;
    valid = 4'b1101;
    tick(g);
    chk("post_rst_sel", po_sel, 0);
    if (g >= 0) valid[g] = 1'b0;

    // Random traffic: producers hold a beat until it transfers.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!valid[k] && $urandom_range(0, 1) == 1) begin
          valid[k]     = 1'b1;
          lane_data[k] = 4'($urandom);
        end
      end
      ready = ($urandom_range(0, 3) != 0);
      tick(g);
      if (g >= 0) valid[g] = 1'b0;
    end

    valid = 4'b0000;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) tick(g);
    chk("sb_left", sb.size(), 0);
    chk("final_valid", po_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_mux_4to1.md
# rr_mux_4to1

Round-robin 4-to-1 stream merger: the gathering counterpart of the 1-to-4 demultiplexer that fans a nibble out to one of four lanes by select. Collects beats from four valid/ready input lanes, arbitrates fairly among the requesting lanes, and presents one registered beat per cycle on a single output with a 2-bit source tag. It sits wherever four producers share one consumer, for example when returning demuxed lanes to a common sink.

## Interface
- DATA_W, 4, width of each lane's data.
- piClk  in  1  clock; all state updates on its rising edge.
- piRst_n  in  1  reset, asynchronous assert, active-low.
- piE  in  4*DATA_W  lane data, packed; lane k is bits [k*DATA_W +: DATA_W].
- piValid  in  4  per-lane valid.
- poReady  out  4  per-lane ready; a lane transfers when its piValid and poReady are both 1.
- poData  out  DATA_W  registered output data.
- poSel  out  2  index of the lane that supplied poData.
- poValid  out  1  output beat present.
- piReady  in  1  consumer ready; the output transfers when poValid and piReady are both 1.

## Operation
- Output stage is a single register with two states:
  - EMPTY: poValid=0.
  - FULL: poValid=1.
- load_ok = !poValid || piReady. The stage can take a new beat when it is empty or is being drained this cycle.
- Arbiter:
  - Holds a 2-bit pointer ptr.
  - The grant goes to the first lane with piValid=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - No lane valid means no grant.
- poReady[g] = load_ok && grant valid, only for the granted lane g; all other bits are 0. poReady is combinational from piValid, poValid and piReady.
- On an accepted input beat:
  - poData <= lane g data.
  - poSel <= g.
  - poValid <= 1.
  - ptr <= g+1 mod 4. This wraps 3 to 0.
- Output drained and nothing accepted: poValid <= 0. poData and poSel hold their stale values.
- Drain and load in the same cycle: the new beat replaces the old one and poValid stays 1, so throughput is 1 beat per cycle.
- No grant: ptr is unchanged.
- Consumer stall (poValid=1, piReady=0):
  - All poReady bits are 0.
  - Output registers hold.
  - ptr holds.
- Producer rules: a producer must hold piValid and its data stable until it transfers. The block never drops or duplicates a beat.
- Reset mid-operation: any buffered beat is discarded and all state returns to its reset values.

## Timing
- Reset values: poValid=0, poData=0, poSel=0, ptr=0.
- poReady is 0 whenever reset is asserted.
- Latency: a lane beat accepted at edge N is visible on poData/poSel/poValid after edge N.
- Fairness: with all four lanes continuously valid and piReady=1, grants cycle 0,1,2,3,0,... with one beat per cycle. No requesting lane waits more than 3 grants.
- Asynchronous reset: takes effect immediately on piRst_n falling, independent of piClk. Release is synchronous to piClk, and the first grant can occur at the first rising edge after release.

## Structure
- Shared package constants:
  - N_LANES=4.
  - SEL_W=2.
  - The lane-slice helper that extracts lane k from the packed bus.
- Sub-module rr_arbiter4:
  - Purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: grant_valid, grant_idx[1:0], grant_onehot[3:0].
  - Reusable by other arbitrated blocks.
- Top level holds ptr, the output register and the handshake logic.

## Test plan
- Reset: drive piRst_n=0 mid-stream with lane 2 holding beat 4'hA in the output -> poValid=0, poData=0, poSel=0, poReady=0 immediately, no clock needed. After release, the first grant starts searching from lane 0.
- Single lane: only lane 1 valid with 4'h5 and piReady=1 -> poReady=4'b0010 that cycle. Next cycle poData=4'h5, poSel=1, poValid=1. Then ptr=2.
- Round-robin: all lanes valid with data 4'h0, 4'h1, 4'h2, 4'h3 and piReady=1 for 8 cycles -> poSel sequence is 0,1,2,3,0,1,2,3 and poData matches each lane.
- Back-pressure: hold piReady=0 while the output is FULL with lane 3's beat 4'hC and lanes 0 and 1 are valid -> poReady=0, and poData=4'hC and poSel=3 hold. Raise piReady -> lane 0 is granted next, because ptr wrapped from 3 to 0.
- Skip idle lanes: ptr=1, only lanes 0 and 3 valid -> lane 3 is granted first, then lane 0; ptr ends at 1.
- Simultaneous drain and load: poValid=1 with 4'h7 from lane 0, piReady=1, lane 2 valid with 4'h9 -> poValid stays 1 and the next cycle shows poData=4'h9, poSel=2. Scoreboard check: no beat is lost or duplicated.
